rrc_symbol_upsampler: RTL and testbench

- Upstream stage of the RRC pulse-shaping filter.
- Accepts symbols over a valid/ready handshake and buffers them in a small FIFO.
- Maps each symbol to a signed amplitude (BPSK or Gray PAM4) and zero-stuffs to OSR samples per symbol.
- Drives one WIDTH-bit signed sample every clock into the filter input, which is free-running with no valid.

---
 rtl/rrc_symbol_upsampler.sv | 219 +++++++++++++++++++++
 tb/tb_rrc_symbol_upsampler.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rrc_symbol_upsampler.sv
`default_nettype none
// ============================================================================
//  Module   : rrc_symbol_upsampler
//  Purpose  : Front end of the RRC pulse-shaping filter. Buffers incoming
//             symbols in a small FIFO, maps each one to a signed amplitude
//             (BPSK or Gray PAM4) and zero-stuffs to OSR samples per symbol.
//             One sample leaves every clock; sample_out is registered.
//  Revision : 1.0  initial release
// ============================================================================
module rrc_symbol_upsampler #(
   parameter int WIDTH = 9,
   parameter int OSR   = 4,
   parameter int DEPTH = 4,
   parameter int MODE  = 1,
   parameter int LVL   = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   sym_valid,
   input  logic [1:0]             sym_data,
   output logic                   sym_ready,
   output logic [WIDTH-1:0]       sample_out,
   output logic                   sample_strobe,
   output logic                   underflow,
   output logic                   underflow_sticky,
   output logic [$clog2(DEPTH):0] fifo_level
);

   // ------------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------------
   localparam int C_AW = $clog2(DEPTH);
   localparam int C_LW = C_AW + 1;
   localparam int C_PW = $clog2(OSR);

   localparam logic [C_LW-1:0]  C_FULL_LEVEL = C_LW'(DEPTH);
   localparam logic [C_LW-1:0]  C_LEVEL_ONE  = C_LW'(1);
   localparam logic [C_AW-1:0]  C_PTR_ONE    = C_AW'(1);
   localparam logic [C_PW-1:0]  C_LAST_PHASE = C_PW'(OSR - 1);
   localparam logic [C_PW-1:0]  C_PHASE_ONE  = C_PW'(1);

   // Amplitudes in two's complement; 3*LVL fits in WIDTH-1 bits so the
   // truncating casts are exact sign extensions.
   localparam logic [WIDTH-1:0] C_POS_OUTER  = WIDTH'(3 * LVL);
   localparam logic [WIDTH-1:0] C_POS_INNER  = WIDTH'(LVL);
   localparam logic [WIDTH-1:0] C_NEG_INNER  = WIDTH'(-LVL);
   localparam logic [WIDTH-1:0] C_NEG_OUTER  = WIDTH'(-3 * LVL);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [1:0]       mem_q [DEPTH];
   logic [1:0]       mem_d [DEPTH];
   logic [C_AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [C_AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [C_LW-1:0]  count_q,  count_d;
   logic [C_PW-1:0]  phase_q,  phase_d;
   logic [WIDTH-1:0] sample_q, sample_d;
   logic             strobe_q, strobe_d;
   logic             uflow_q,  uflow_d;
   logic             sticky_q, sticky_d;

   // ------------------------------------------------------------------------
   // Handshake and slot decode
   // ------------------------------------------------------------------------
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_slot;
   logic             w_pop;
   logic [1:0]       w_head;
   logic [WIDTH-1:0] w_mapped;

   assign w_full  = (count_q == C_FULL_LEVEL);
   assign w_empty = (count_q == '0);
   // Ready comes only from the registered count; a pop in this cycle does
   // not open a slot until the next cycle.
   assign w_push  = sym_valid & ~w_full;
   // A symbol slot is phase 0 while running.
   assign w_slot  = en & (phase_q == '0);
   // The pop decision uses the registered count, so a same-edge push into an
   // empty FIFO is never bypassed into the slot.
   assign w_pop   = w_slot & ~w_empty;
   assign w_head  = mem_q[rd_ptr_q];

   // ------------------------------------------------------------------------
   // Symbol to amplitude mapping
   // ------------------------------------------------------------------------
   generate
      if (MODE == 0) begin : g_map_bpsk
         // Only bit 0 carries information in BPSK.
         assign w_mapped = w_head[0] ? C_NEG_OUTER : C_POS_OUTER;
      end else begin : g_map_pam4
         // Gray order: adjacent amplitude levels differ in a single bit.
         always_comb begin
            unique case (w_head)
               2'b00:   w_mapped = C_POS_OUTER;
               2'b01:   w_mapped = C_POS_INNER;
               2'b11:   w_mapped = C_NEG_INNER;
               default: w_mapped = C_NEG_OUTER;
            endcase
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // FIFO next state: storage write, pointer advance, occupancy
   // ------------------------------------------------------------------------
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (w_push) begin
         mem_d[wr_ptr_q] = sym_data;
         wr_ptr_d        = wr_ptr_q + C_PTR_ONE;
      end

      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      end

      // Simultaneous push and pop leaves the occupancy unchanged.
      unique case ({w_push, w_pop})
         2'b10:   count_d = count_q + C_LEVEL_ONE;
         2'b01:   count_d = count_q - C_LEVEL_ONE;
         default: count_d = count_q;
      endcase
   end

   // Phase counter: runs 0..OSR-1 while enabled, parks at 0 otherwise.
   always_comb begin
      phase_d = '0;
      if (en) begin
         if (phase_q == C_LAST_PHASE) begin
            phase_d = '0;
         end else begin
            phase_d = phase_q + C_PHASE_ONE;
         end
      end
   end

   // Output sample: mapped symbol at a filled slot, zero everywhere else.
   always_comb begin
      sample_d = '0;
      strobe_d = 1'b0;
      uflow_d  = 1'b0;
      sticky_d = sticky_q;

      if (w_slot) begin
         strobe_d = 1'b1;
         if (w_empty) begin
            uflow_d  = 1'b1;
            sticky_d = 1'b1;
         end else begin
            sample_d = w_mapped;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------

   // Symbol storage; cleared on reset so stale symbols can never resurface.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // FIFO pointers, occupancy and phase.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         phase_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         phase_q  <= phase_d;
      end
   end

   // Registered sample path and underflow flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sample_q <= '0;
         strobe_q <= 1'b0;
         uflow_q  <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         sample_q <= sample_d;
         strobe_q <= strobe_d;
         uflow_q  <= uflow_d;
         sticky_q <= sticky_d;
      end
   end

   // ------------------------------------------------------------------------
   // Port drive
   // ------------------------------------------------------------------------
   assign sym_ready        = ~w_full;
   assign sample_out       = sample_q;
   assign sample_strobe    = strobe_q;
   assign underflow        = uflow_q;
   assign underflow_sticky = sticky_q;
   assign fifo_level       = count_q;

endmodule
`default_nettype wire

// File: tb/tb_rrc_symbol_upsampler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rrc_symbol_upsampler
//  Purpose  : Self-checking bench for rrc_symbol_upsampler. Instance dut uses
//             the defaults (PAM4, OSR=4, DEPTH=4); instance dut_b is BPSK
//             with OSR=2. Accepted symbols push their expected amplitude
//             into a queue that is popped at each symbol slot.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rrc_symbol_upsampler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // PAM4 instance signals
   logic       rst;
   logic       en;
   logic       sym_valid;
   logic [1:0] sym_data;
   logic       sym_ready;
   logic [8:0] sample_out;
   logic       sample_strobe;
   logic       underflow;
   logic       underflow_sticky;
   logic [2:0] fifo_level;

   // BPSK instance signals
   logic       en_b;
   logic       sym_valid_b;
   logic [1:0] sym_data_b;
   logic       sym_ready_b;
   logic [8:0] sample_out_b;
   logic       sample_strobe_b;
   logic       underflow_b;
   logic       underflow_sticky_b;
   logic [2:0] fifo_level_b;

   rrc_symbol_upsampler #(.WIDTH(9), .OSR(4), .DEPTH(4), .MODE(1), .LVL(32)) dut (
      .clk(clk), .rst(rst), .en(en), .sym_valid(sym_valid), .sym_data(sym_data),
      .sym_ready(sym_ready), .sample_out(sample_out), .sample_strobe(sample_strobe),
      .underflow(underflow), .underflow_sticky(underflow_sticky), .fifo_level(fifo_level)
   );

   rrc_symbol_upsampler #(.WIDTH(9), .OSR(2), .DEPTH(4), .MODE(0), .LVL(32)) dut_b (
      .clk(clk), .rst(rst), .en(en_b), .sym_valid(sym_valid_b), .sym_data(sym_data_b),
      .sym_ready(sym_ready_b), .sample_out(sample_out_b), .sample_strobe(sample_strobe_b),
      .underflow(underflow_b), .underflow_sticky(underflow_sticky_b), .fifo_level(fifo_level_b)
   );

   int n_vec = 0;
   int n_err = 0;

   // Scoreboard and reference state for the PAM4 instance
   logic [8:0] mq[$];
   int         m_phase;
   bit         m_pushed;
   logic [8:0] exp_sample;
   logic       exp_strobe;
   logic       exp_uf;
   logic       exp_sticky;
   logic [15:0] exp_vec;

   function automatic logic [8:0] pam4_amp(input logic [1:0] s);
      case (s)
         2'b00:   return 9'd96;
         2'b01:   return 9'd32;
         2'b11:   return -9'sd32;
         default: return -9'sd96;
      endcase
   endfunction

   function automatic logic [15:0] obs_vec();
      return {sample_out, sample_strobe, underflow, underflow_sticky, fifo_level, sym_ready};
   endfunction

   // One clock of the PAM4 instance: update the reference from the inputs
   // present at the edge, then step to 1 time unit after the edge.
   task automatic tick();
      bit slot;
      bit push;
      push       = sym_valid && (mq.size() < 4);
      slot       = en && (m_phase == 0);
      exp_sample = '0;
      exp_strobe = 1'b0;
      exp_uf     = 1'b0;
      if (slot) begin
         exp_strobe = 1'b1;
         if (mq.size() > 0) begin
            exp_sample = mq.pop_front();
         end else begin
            exp_uf     = 1'b1;
            exp_sticky = 1'b1;
         end
      end
      if (push) mq.push_back(pam4_amp(sym_data));
      m_pushed = push;
      m_phase  = en ? ((m_phase + 1) % 4) : 0;
      exp_vec  = {exp_sample, exp_strobe, exp_uf, exp_sticky, 3'(mq.size()), (mq.size() < 4)};
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      en          = 1'b0;
      sym_valid   = 1'b0;
      en_b        = 1'b0;
      sym_valid_b = 1'b0;
      rst         = 1'b0;
      mq.delete();
      m_phase     = 0;
      exp_sticky  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      // rst already low: everything must be idle without any clock edge
      n_vec++;
      if ({sample_out, sample_strobe, underflow, underflow_sticky, fifo_level, sym_ready} !== {9'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1}) begin
         n_err++;
         $display("FAIL reset_idle: got out=%0d stb=%b uf=%b st=%b lvl=%0d rdy=%b want all 0, rdy=1",
                  $signed(sample_out), sample_strobe, underflow, underflow_sticky, fifo_level, sym_ready);
      end
      n_vec++;
      if ({sample_out_b, underflow_sticky_b, fifo_level_b, sym_ready_b} !== {9'd0, 1'b0, 3'd0, 1'b1}) begin
         n_err++;
         $display("FAIL reset_idle_b: got out=%0d st=%b lvl=%0d rdy=%b want 0/0/0/1",
                  $signed(sample_out_b), underflow_sticky_b, fifo_level_b, sym_ready_b);
      end
      do_reset();
   endtask

   task automatic test_pam4();
      logic [1:0] syms [4];
      int         seq  [20];
      syms = '{2'b00, 2'b01, 2'b11, 2'b10};
      seq  = '{0,0,0,0, 96,0,0,0, 32,0,0,0, -32,0,0,0, -96,0,0,0};
      do_reset();
      en        = 1'b1;
      sym_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (k < 4) sym_data = syms[k];
         else       sym_valid = 1'b0;
         tick();
         n_vec++;
         if (obs_vec() !== exp_vec) begin
            n_err++;
            $display("FAIL pam4 cyc %0d: got %h want %h", k, obs_vec(), exp_vec);
         end
         n_vec++;
         if (sample_out !== 9'(seq[k]) || sample_strobe !== (k % 4 == 0) || underflow !== (k == 0)) begin
            n_err++;
            $display("FAIL pam4_seq cyc %0d: got out=%0d stb=%b uf=%b want out=%0d stb=%b uf=%b",
                     k, $signed(sample_out), sample_strobe, underflow, seq[k], (k % 4 == 0), (k == 0));
         end
      end
   endtask

   task automatic test_underflow();
      do_reset();
      sym_valid = 1'b1;
      sym_data  = 2'b01;
      tick();
      sym_valid = 1'b0;
      en        = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         n_vec++;
         if (obs_vec() !== exp_vec) begin
            n_err++;
            $display("FAIL underflow cyc %0d: got %h want %h", k, obs_vec(), exp_vec);
         end
         n_vec++;
         if (underflow !== (k == 4) || underflow_sticky !== (k >= 4)) begin
            n_err++;
            $display("FAIL underflow_pulse cyc %0d: got uf=%b st=%b want uf=%b st=%b",
                     k, underflow, underflow_sticky, (k == 4), (k >= 4));
         end
      end
      en = 1'b0;
      repeat (5) tick();
      n_vec++;
      if (underflow_sticky !== 1'b1 || underflow !== 1'b0) begin
         n_err++;
         $display("FAIL sticky_hold: got st=%b uf=%b want st=1 uf=0", underflow_sticky, underflow);
      end
      // Asynchronous clear of the sticky flag, away from any clock edge
      #2;
      rst = 1'b0;
      #1;
      n_vec++;
      if (underflow_sticky !== 1'b0) begin
         n_err++;
         $display("FAIL sticky_async_clear: got %b want 0", underflow_sticky);
      end
      do_reset();
   endtask

   task automatic test_backpressure();
      logic [1:0] syms [5];
      syms = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b11};
      do_reset();
      sym_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         sym_data = syms[k];
         tick();
         n_vec++;
         if (fifo_level !== 3'(k + 1) || sym_ready !== (k < 3)) begin
            n_err++;
            $display("FAIL bp_fill %0d: got lvl=%0d rdy=%b want lvl=%0d rdy=%b",
                     k, fifo_level, sym_ready, k + 1, (k < 3));
         end
      end
      sym_data = syms[4];
      repeat (3) tick();
      n_vec++;
      if (fifo_level !== 3'd4 || sym_ready !== 1'b0) begin
         n_err++;
         $display("FAIL bp_hold: got lvl=%0d rdy=%b want lvl=4 rdy=0", fifo_level, sym_ready);
      end
      // Slot pop coincides with a waiting symbol: no push on this edge
      en = 1'b1;
      tick();
      n_vec++;
      if (fifo_level !== 3'd3 || sym_ready !== 1'b1 || sample_out !== -9'sd96 || sample_strobe !== 1'b1) begin
         n_err++;
         $display("FAIL bp_pop: got lvl=%0d rdy=%b out=%0d stb=%b want lvl=3 rdy=1 out=-96 stb=1",
                  fifo_level, sym_ready, $signed(sample_out), sample_strobe);
      end
      tick();
      n_vec++;
      if (fifo_level !== 3'd4 || sym_ready !== 1'b0 || !m_pushed) begin
         n_err++;
         $display("FAIL bp_late_push: got lvl=%0d rdy=%b want lvl=4 rdy=0", fifo_level, sym_ready);
      end
      sym_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         n_vec++;
         if (obs_vec() !== exp_vec) begin
            n_err++;
            $display("FAIL bp_drain cyc %0d: got %h want %h", k, obs_vec(), exp_vec);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      en        = 1'b1;
      sym_valid = 1'b1;
      sym_data  = 2'($urandom_range(0, 3));
      for (int k = 0; k < 60; k++) begin
         tick();
         // new data only once the previous one was accepted
         if (m_pushed) sym_data = 2'($urandom_range(0, 3));
         n_vec++;
         if (obs_vec() !== exp_vec) begin
            n_err++;
            $display("FAIL b2b cyc %0d: got %h want %h", k, obs_vec(), exp_vec);
         end
         if (k > 0) begin
            n_vec++;
            if (underflow !== 1'b0) begin
               n_err++;
               $display("FAIL b2b_no_underflow cyc %0d: got uf=%b want 0", k, underflow);
            end
         end
      end
      sym_valid = 1'b0;
   endtask

   task automatic test_reset_midop();
      do_reset();
      sym_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         sym_data = 2'b00;
         tick();
      end
      sym_valid = 1'b0;
      en        = 1'b1;
      tick();
      n_vec++;
      if (sample_out !== 9'd96 || fifo_level !== 3'd3) begin
         n_err++;
         $display("FAIL midop_pre: got out=%0d lvl=%0d want out=96 lvl=3", $signed(sample_out), fifo_level);
      end
      #2;
      en  = 1'b0;
      rst = 1'b0;
      #1;
      n_vec++;
      if ({sample_out, sample_strobe, underflow, underflow_sticky, fifo_level, sym_ready} !== {9'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1}) begin
         n_err++;
         $display("FAIL midop_async: got out=%0d stb=%b uf=%b st=%b lvl=%0d rdy=%b want all 0, rdy=1",
                  $signed(sample_out), sample_strobe, underflow, underflow_sticky, fifo_level, sym_ready);
      end
      do_reset();
      en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         n_vec++;
         if (sample_out !== 9'd0 || underflow !== (k % 4 == 0) || obs_vec() !== exp_vec) begin
            n_err++;
            $display("FAIL midop_lost cyc %0d: got %h want %h", k, obs_vec(), exp_vec);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_bpsk();
      int   seq [10];
      logic b;
      seq = '{96, 0, -96, 0, 96, 0, -96, 0, 0, 0};
      do_reset();
      sym_valid_b = 1'b1;
      for (int k = 0; k < 4; k++) begin
         b          = (k % 2 == 1);
         sym_data_b = {1'($urandom_range(0, 1)), b};
         @(posedge clk);
         #1;
         n_vec++;
         if (fifo_level_b !== 3'(k + 1)) begin
            n_err++;
            $display("FAIL bpsk_fill %0d: got lvl=%0d want %0d", k, fifo_level_b, k + 1);
         end
      end
      sym_valid_b = 1'b0;
      en_b        = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         n_vec++;
         if (sample_out_b !== 9'(seq[k]) || sample_strobe_b !== (k % 2 == 0) ||
             underflow_b !== (k == 8) || underflow_sticky_b !== (k >= 8)) begin
            n_err++;
            $display("FAIL bpsk cyc %0d: got out=%0d stb=%b uf=%b st=%b want out=%0d stb=%b uf=%b st=%b",
                     k, $signed(sample_out_b), sample_strobe_b, underflow_b, underflow_sticky_b,
                     seq[k], (k % 2 == 0), (k == 8), (k >= 8));
         end
      end
      en_b = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      en          = 1'b0;
      sym_valid   = 1'b0;
      sym_data    = 2'b00;
      en_b        = 1'b0;
      sym_valid_b = 1'b0;
      sym_data_b  = 2'b00;
      m_phase     = 0;
      exp_sticky  = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      test_reset();
      test_pam4();
      test_underflow();
      test_backpressure();
      test_back_to_back();
      test_reset_midop();
      test_bpsk();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
